dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_OFF = 2;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Word-index width for a power-of-two word count.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: one synchronous write port, one asynchronous read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the D-cache: X-stage address, M-stage write/read data.
//
// state | meaning
// INIT  | zero-filling the array, one word per cycle; inputs ignored
// READY | normal read/write service; left only through rst_i
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       dm_addr_i,
    input  logic              dm_wen_i,
    input  logic [WORD_W-1:0] dm_din_i,
    output logic [WORD_W-1:0] dm_dout_o,
    output logic              init_done_o,
    output logic              err_oob_o,
    output logic              err_misalign_o
);

    localparam int               IDX_W    = idx_w(DEPTH);
    localparam logic [32:0]      SPAN     = 33'(DEPTH) << BYTE_OFF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0]       addr_q, addr_d;
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              err_oob_q, err_oob_d;
    logic              err_mis_q, err_mis_d;
    logic              live_q, live_d;

    logic [32:0]       off;
    logic              in_range;
    logic              misalign;
    logic              access_qual;
    logic [IDX_W-1:0]  idx;

    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    // Decode of the M-stage address; a borrow in the 33-bit offset means below BASE_ADDR.
    always_comb begin
        off         = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        in_range    = off < SPAN;
        idx         = off[IDX_W+BYTE_OFF-1:BYTE_OFF];
        misalign    = addr_q[BYTE_OFF-1:0] != '0;
        // The cache drives an address every cycle, so only real writes or a nonzero
        // address seen after at least one cycle out of reset count as an access.
        access_qual = dm_wen_i || (live_q && (addr_q != '0));
    end

    // Next-state logic for the fill sequencer, address capture and sticky error flags.
    always_comb begin
        addr_d     = dm_addr_i;
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        err_oob_d  = err_oob_q;
        err_mis_d  = err_mis_q;
        live_d     = 1'b1;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (access_qual) begin
                    if (!in_range) err_oob_d = 1'b1;
                    if (misalign)  err_mis_d = 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-fill restarts at word 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            state_q    <= INIT_ZERO ? INIT : READY;
            init_cnt_q <= '0;
            err_oob_q  <= 1'b0;
            err_mis_q  <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            err_oob_q  <= err_oob_d;
            err_mis_q  <= err_mis_d;
            live_q     <= live_d;
        end
    end

    // Write-port mux: fill zeros during INIT, in-range M-stage writes during READY.
    always_comb begin
        if (state_q == INIT) begin
            we    = !rst_i;
            waddr = init_cnt_q;
            wdata = '0;
        end else begin
            we    = !rst_i && dm_wen_i && in_range;
            waddr = idx;
            wdata = dm_din_i;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

    // Read is combinational off addr_q so data lands in the M cycle (read-before-write).
    assign dm_dout_o      = (!rst_i && state_q == READY && in_range) ? rdata : '0;
    assign init_done_o    = !rst_i && (state_q == READY);
    assign err_oob_o      = err_oob_q;
    assign err_misalign_o = err_mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH=16, BASE_ADDR=0, INIT_ZERO=1).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        done;
    logic        oob;
    logic        mis;

    typedef struct {
        int          cyc;
        string       nm;
        logic [31:0] dout;
        logic        done;
        logic        oob;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_mis  = 0;

    dmem_responder #(
        .DEPTH     (16),
        .BASE_ADDR (32'h0000_0000),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .dm_addr_i      (addr),
        .dm_wen_i       (wen),
        .dm_din_i       (din),
        .dm_dout_o      (dout),
        .init_done_o    (done),
        .err_oob_o      (oob),
        .err_misalign_o (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compares every output against the expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL %s missed: expected at cycle %0d, now cycle %0d", e.nm, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (dout !== e.dout || done !== e.done || oob !== e.oob || mis !== e.mis) begin
                n_mis++;
                $display("FAIL %s @cyc %0d: got dout=%h done=%b oob=%b mis=%b, want dout=%h done=%b oob=%b mis=%b",
                         e.nm, cyc, dout, done, oob, mis, e.dout, e.done, e.oob, e.mis);
            end
        end
    end

    // Drive one cycle of inputs, optionally queue the outputs expected in that cycle.
    task automatic cyc_do(input logic [31:0] a, input logic w, input logic [31:0] d, input logic r,
                          input string nm, input logic [31:0] ed, input logic edone,
                          input logic eoob, input logic emis, input bit chk);
        exp_t x;
        rst  = r;
        addr = a;
        wen  = w;
        din  = d;
        if (chk) begin
            x.cyc  = cyc;
            x.nm   = nm;
            x.dout = ed;
            x.done = edone;
            x.oob  = eoob;
            x.mis  = emis;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        addr = '0;
        wen  = 1'b0;
        din  = '0;

        // Reset, then the first fill: writes during INIT must be ignored.
        cyc_do(32'h0, 1'b0, 32'h0, 1'b1, "pre", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_do(32'h0, 1'b0, 32'h0, 1'b1, "reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            cyc_do(32'(i * 4), 1'b1, 32'hFFFF_FFFF, 1'b0, "init", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Directed traffic: store/load, read-before-write, out-of-range, misaligned.
        cyc_do(32'h00, 1'b0, 32'h0,         1'b0, "ready_rise",  32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h10, 1'b0, 32'h0,         1'b0, "read0",       32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h00, 1'b1, 32'hDEAD_BEEF, 1'b0, "st_m",        32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h10, 1'b0, 32'h0,         1'b0, "st_idle",     32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h08, 1'b0, 32'h0,         1'b0, "st_ld",       32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h08, 1'b1, 32'h1234_5678, 1'b0, "rbw_old",     32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h00, 1'b0, 32'h0,         1'b0, "rbw_new",     32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h40, 1'b0, 32'h0,         1'b0, "pre_oob",     32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h40, 1'b1, 32'hFFFF_FFFF, 1'b0, "oob_m",       32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h3C, 1'b0, 32'h0,         1'b0, "oob_rd",      32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
        cyc_do(32'h00, 1'b0, 32'h0,         1'b0, "oob_w15",     32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
        cyc_do(32'h06, 1'b0, 32'h0,         1'b0, "oob_w0",      32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
        cyc_do(32'h04, 1'b1, 32'hA5A5_A5A5, 1'b0, "mis_m",       32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
        cyc_do(32'h10, 1'b0, 32'h0,         1'b0, "mis_rd",      32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc_do(32'h08, 1'b0, 32'h0,         1'b0, "keep4",       32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc_do(32'h00, 1'b0, 32'h0,         1'b0, "keep2",       32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset with flags set, then reset again in the middle of the fill.
        cyc_do(32'h10, 1'b0, 32'h0, 1'b1, "rst_hold", 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc_do(32'h10, 1'b0, 32'h0, 1'b1, "rst_clr",  32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc_do(32'h0, 1'b0, 32'h0, 1'b0, "init_a", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h0, 1'b0, 32'h0, 1'b1, "rst_mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            cyc_do(32'h0, 1'b0, 32'h0, 1'b0, "init_b", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h10, 1'b0, 32'h0, 1'b0, "reinit_rise", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h08, 1'b0, 32'h0, 1'b0, "reinit_4",    32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_do(32'h00, 1'b0, 32'h0, 1'b0, "reinit_2",    32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL %s never compared: queued for cycle %0d", e.nm, e.cyc);
        end

        #1;
        n_cmp++;
        if (done !== 1'b1) begin
            n_mis++;
            $display("FAIL final: init_done_o=%b, want 1", done);
        end
        n_cmp++;
        if (oob !== 1'b0) begin
            n_mis++;
            $display("FAIL final: err_oob_o=%b, want 0", oob);
        end
        n_cmp++;
        if (mis !== 1'b0) begin
            n_mis++;
            $display("FAIL final: err_misalign_o=%b, want 0", mis);
        end
        n_cmp++;
        if (dout !== 32'h0) begin
            n_mis++;
            $display("FAIL final: dm_dout_o=%h, want 0", dout);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        if (n_mis != 0) $display("TEST FAILED");
        else            $display("TEST PASSED");
        $finish;
    end

endmodule
